// File: rtl/noise_seq_pkg.sv
// Shared types and constants for the noise-measurement sequencer:
// FSM states, control-bit positions and the per-phase config address layout.
package noise_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int BIT_DUMPON  = 0;
   localparam int BIT_DUMPOFF = 1;
   localparam int BIT_SOFT_D  = 2;
   localparam int BIT_RT_SW   = 3;
   localparam int BIT_SW_ACQ1 = 4;
   localparam int BIT_SW_ACQ2 = 5;
   localparam int BIT_N_ACQ   = 6;

   // Each phase occupies three consecutive config words.
   localparam int DUR_LO   = 0;
   localparam int DUR_HI   = 1;
   localparam int PAT      = 2;
   localparam int LAST_BIT = 15;

endpackage

// File: rtl/noise_seq_if.sv
// Host DSP configuration write bus for noise_seq, with the reject pulse
// returned by the sequencer.
interface noise_seq_if #(
   parameter int NUM_PHASES = 8,
   parameter int DATA_W     = 16
);
   localparam int ADDR_W = $clog2(3 * NUM_PHASES + 1);

   logic              cfg_wr;
   logic [ADDR_W-1:0] cfg_addr;
   logic [DATA_W-1:0] cfg_data;
   logic              cfg_rej;

   modport master (output cfg_wr, output cfg_addr, output cfg_data, input cfg_rej);
   modport slave  (input cfg_wr, input cfg_addr, input cfg_data, output cfg_rej);
endinterface

// File: rtl/noise_seq_timer.sv
// Loadable down-counter timing one phase; expire_o is high in the last
// enabled cycle of the loaded interval (load value = cycles - 1).
module noise_seq_timer #(
   parameter int TIME_W = 20
) (
   input  logic              clk_sys,
   input  logic              rst,
   input  logic              load_i,
   input  logic [TIME_W-1:0] val_i,
   input  logic              en_i,
   output logic              expire_o
);
   logic [TIME_W-1:0] cnt_q;

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - TIME_W'(1);
      end
   end

   assign expire_o = en_i && (cnt_q == '0);
endmodule

// File: rtl/noise_seq.sv
// Programmable phase sequencer driving the analog-switch/dump controls.
// Optional abort input is enabled by defining NOISE_SEQ_ABORT_EN.
module noise_seq
   import noise_seq_pkg::*;
#(
   parameter int TIME_W     = 20,
   parameter int NUM_PHASES = 8,
   parameter int OUT_W      = 7,
   parameter int DATA_W     = 16,
   parameter int REP_W      = 16
) (
   input  logic             clk_sys,
   input  logic             rst,
   input  logic             start,
`ifdef NOISE_SEQ_ABORT_EN
   input  logic             abort,
`endif
   noise_seq_if.slave       cfg,
   output logic [OUT_W-1:0] ctrl_out,
   output logic             busy,
   output logic [3:0]       phase_idx,
   output logic [REP_W-1:0] pass_cnt,
   output logic             done_n
);
   localparam int ADDR_W = $clog2(3 * NUM_PHASES + 1);

   state_e            state_q;
   logic [OUT_W-1:0]  ctrl_q;
   logic              busy_q;
   logic [3:0]        phase_q;
   logic [REP_W-1:0]  pass_q;
   logic              done_n_q;
   logic              cfg_rej_q;

   logic [TIME_W-1:0] dur_q  [NUM_PHASES];
   logic [OUT_W-1:0]  pat_q  [NUM_PHASES];
   logic              last_q [NUM_PHASES];
   logic [REP_W-1:0]  rep_q;

   logic              abort_w;
   logic              wr_ok;
   logic              eop;
   logic              more;
   logic              tmr_load;
   logic              tmr_exp;
   logic [3:0]        nxt_idx;
   logic [TIME_W-1:0] nxt_dur;
   logic [OUT_W-1:0]  nxt_pat;
   logic              cur_last;
   logic [TIME_W-1:0] dur_m1;
   logic [REP_W-1:0]  rep_eff;
   logic [REP_W-1:0]  pass_d;

`ifdef NOISE_SEQ_ABORT_EN
   assign abort_w = abort && (state_q == RUN);
`else
   assign abort_w = 1'b0;
`endif

   // The table is writable only while idle; the range check covers the repeat word.
   assign wr_ok = cfg.cfg_wr && (state_q == IDLE) &&
                  (cfg.cfg_addr <= ADDR_W'(3 * NUM_PHASES));

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PHASES; gi++) begin : g_tab
         logic wr_lo, wr_hi, wr_pat;
         assign wr_lo  = wr_ok && (cfg.cfg_addr == ADDR_W'(3 * gi + DUR_LO));
         assign wr_hi  = wr_ok && (cfg.cfg_addr == ADDR_W'(3 * gi + DUR_HI));
         assign wr_pat = wr_ok && (cfg.cfg_addr == ADDR_W'(3 * gi + PAT));

         always_ff @(posedge clk_sys or posedge rst) begin
            if (rst) begin
               dur_q[gi]  <= '0;
               pat_q[gi]  <= '0;
               last_q[gi] <= 1'b0;
            end else begin
               if (wr_lo)  dur_q[gi][15:0]        <= cfg.cfg_data[15:0];
               if (wr_hi)  dur_q[gi][TIME_W-1:16] <= cfg.cfg_data[TIME_W-17:0];
               if (wr_pat) begin
                  pat_q[gi]  <= cfg.cfg_data[OUT_W-1:0];
                  last_q[gi] <= cfg.cfg_data[LAST_BIT];
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         rep_q <= '0;
      end else if (wr_ok && (cfg.cfg_addr == ADDR_W'(3 * NUM_PHASES))) begin
         rep_q <= REP_W'(cfg.cfg_data);
      end
   end

   // Table lookups: current phase's LAST flag, and the phase about to be loaded.
   always_comb begin
      nxt_dur  = '0;
      nxt_pat  = '0;
      cur_last = 1'b0;
      for (int i = 0; i < NUM_PHASES; i++) begin
         if (nxt_idx == 4'(i)) begin
            nxt_dur = dur_q[i];
            nxt_pat = pat_q[i];
         end
         if (phase_q == 4'(i)) cur_last = last_q[i];
      end
   end

   assign eop      = cur_last || (phase_q == 4'(NUM_PHASES - 1));
   assign nxt_idx  = ((state_q == RUN) && !eop) ? phase_q + 4'd1 : 4'd0;
   assign dur_m1   = (nxt_dur == '0) ? '0 : nxt_dur - TIME_W'(1);
   assign rep_eff  = (rep_q == '0) ? REP_W'(1) : rep_q;
   assign pass_d   = (pass_q == '1) ? pass_q : pass_q + REP_W'(1);
   assign more     = ({1'b0, pass_q} + (REP_W + 1)'(1)) < {1'b0, rep_eff};
   assign tmr_load = ((state_q == IDLE) && start) ||
                     ((state_q == RUN) && !abort_w && tmr_exp && (!eop || more));

   noise_seq_timer #(.TIME_W(TIME_W)) u_timer (
      .clk_sys  (clk_sys),
      .rst      (rst),
      .load_i   (tmr_load),
      .val_i    (dur_m1),
      .en_i     (state_q == RUN),
      .expire_o (tmr_exp)
   );

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ctrl_q    <= '0;
         busy_q    <= 1'b0;
         phase_q   <= '0;
         pass_q    <= '0;
         done_n_q  <= 1'b1;
         cfg_rej_q <= 1'b0;
      end else begin
         cfg_rej_q <= cfg.cfg_wr && !wr_ok;
         done_n_q  <= 1'b1;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
                  phase_q <= 4'd0;
                  pass_q  <= '0;
                  ctrl_q  <= nxt_pat;
               end
            end
            RUN: begin
               if (abort_w || (tmr_exp && eop && !more)) begin
                  if (!abort_w) pass_q <= pass_d;
                  state_q  <= DONE;
                  ctrl_q   <= '0;
                  busy_q   <= 1'b0;
                  phase_q  <= 4'd0;
                  done_n_q <= 1'b0;
               end else if (tmr_exp) begin
                  if (eop) pass_q <= pass_d;
                  phase_q <= nxt_idx;
                  ctrl_q  <= nxt_pat;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ctrl_out    = ctrl_q;
   assign busy        = busy_q;
   assign phase_idx   = phase_q;
   assign pass_cnt    = pass_q;
   assign done_n      = done_n_q;
   assign cfg.cfg_rej = cfg_rej_q;
endmodule

// File: tb/tb_noise_seq.sv
// Directed self-checking bench for noise_seq (default parameters); the abort
// test is compiled in when NOISE_SEQ_ABORT_EN is defined.
module tb_noise_seq;
   logic        clk_sys = 1'b0;
   logic        rst     = 1'b1;
   logic        start   = 1'b0;
   logic        abort   = 1'b0;
   logic [6:0]  ctrl_out;
   logic        busy;
   logic [3:0]  phase_idx;
   logic [15:0] pass_cnt;
   logic        done_n;

   int checks = 0;
   int errors = 0;

   noise_seq_if #(.NUM_PHASES(8), .DATA_W(16)) cfg_if ();

   noise_seq dut (
      .clk_sys   (clk_sys),
      .rst       (rst),
      .start     (start),
`ifdef NOISE_SEQ_ABORT_EN
      .abort     (abort),
`endif
      .cfg       (cfg_if),
      .ctrl_out  (ctrl_out),
      .busy      (busy),
      .phase_idx (phase_idx),
      .pass_cnt  (pass_cnt),
      .done_n    (done_n)
   );

   always #5 clk_sys = ~clk_sys;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        start;
      logic        wr;
      logic [4:0]  addr;
      logic [15:0] data;
      logic [6:0]  e_ctrl;
      logic        e_busy;
      logic [3:0]  e_ph;
      logic        chk_ph;
      logic [15:0] e_pass;
      logic        e_done_n;
      logic        e_rej;
   } vec_t;

   vec_t vecs[32];
   int   nv = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end else begin
         $display("ok   %s = %0h", nm, act);
      end
   endtask

   task automatic add(input logic [6:0] c, input logic b, input logic [3:0] ph,
                      input logic cp, input logic [15:0] ps, input logic dn);
      vecs[nv] = '{1'b0, 1'b0, 5'd0, 16'd0, c, b, ph, cp, ps, dn, 1'b0};
      nv++;
   endtask

   // Called at a falling edge; the write commits at the next rising edge.
   task automatic wr(input logic [4:0] a, input logic [15:0] d, output logic rej);
      cfg_if.cfg_wr   = 1'b1;
      cfg_if.cfg_addr = a;
      cfg_if.cfg_data = d;
      @(negedge clk_sys);
      cfg_if.cfg_wr = 1'b0;
      rej = cfg_if.cfg_rej;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk_sys);
      start = 1'b0;
   endtask

   // Counts busy cycles of a run started here; flags cycles whose pattern differs.
   task automatic run_measure(input logic [6:0] pat, output int n, output int bad);
      n = 0;
      bad = 0;
      pulse_start();
      while (busy === 1'b1 && n < 50) begin
         if (ctrl_out !== pat) bad++;
         n++;
         @(negedge clk_sys);
      end
   endtask

   initial begin
      logic       rej;
      int         n, bad;
      logic [6:0] seen[4];

      cfg_if.cfg_wr   = 1'b0;
      cfg_if.cfg_addr = '0;
      cfg_if.cfg_data = '0;
      repeat (3) @(negedge clk_sys);
      chk("rst_ctrl", 32'(ctrl_out), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_phase", 32'(phase_idx), 0);
      chk("rst_pass", 32'(pass_cnt), 0);
      chk("rst_done_n", 32'(done_n), 1);
      chk("rst_rej", 32'(cfg_if.cfg_rej), 0);
      rst = 1'b0;
      @(negedge clk_sys);

      // Single phase, D=3, LAST, R=1.
      wr(5'd0, 16'd3, rej);
      chk("t1_wr_rej", 32'(rej), 0);
      wr(5'd1, 16'd0, rej);
      wr(5'd2, 16'h8011, rej);
      wr(5'd24, 16'd1, rej);
      pulse_start();
      for (int k = 0; k < 3; k++) begin
         chk("t1_ctrl", 32'(ctrl_out), 32'h11);
         chk("t1_busy", 32'(busy), 1);
         chk("t1_phase", 32'(phase_idx), 0);
         @(negedge clk_sys);
      end
      chk("t1_done_ctrl", 32'(ctrl_out), 0);
      chk("t1_done_n", 32'(done_n), 0);
      chk("t1_done_busy", 32'(busy), 0);
      chk("t1_done_pass", 32'(pass_cnt), 1);
      @(negedge clk_sys);
      chk("t1_idle_done_n", 32'(done_n), 1);
      chk("t1_idle_pass", 32'(pass_cnt), 1);

      // Three phases D=2,0,5, LAST on phase 2, R=2.
      wr(5'd0, 16'd2, rej);
      wr(5'd2, 16'h0001, rej);
      wr(5'd3, 16'd0, rej);
      wr(5'd4, 16'd0, rej);
      wr(5'd5, 16'h0002, rej);
      wr(5'd6, 16'd5, rej);
      wr(5'd7, 16'd0, rej);
      wr(5'd8, 16'h8040, rej);
      wr(5'd24, 16'd2, rej);

      nv = 0;
      add(7'h00, 1'b0, 4'd0, 1'b0, 16'd1, 1'b1);
      for (int p = 0; p < 2; p++) begin
         repeat (2) add(7'h01, 1'b1, 4'd0, 1'b1, 16'(p), 1'b1);
         add(7'h02, 1'b1, 4'd1, 1'b1, 16'(p), 1'b1);
         repeat (5) add(7'h40, 1'b1, 4'd2, 1'b1, 16'(p), 1'b1);
      end
      add(7'h00, 1'b0, 4'd0, 1'b0, 16'd2, 1'b0);
      add(7'h00, 1'b0, 4'd0, 1'b0, 16'd2, 1'b1);
      add(7'h00, 1'b0, 4'd0, 1'b0, 16'd2, 1'b1);
      vecs[0].start  = 1'b1;
      vecs[5].start  = 1'b1;
      vecs[7].wr     = 1'b1;
      vecs[7].addr   = 5'd0;
      vecs[7].data   = 16'd7;
      vecs[8].e_rej  = 1'b1;
      vecs[17].start = 1'b1;

      for (int i = 0; i < nv; i++) begin
         chk($sformatf("t2[%0d]_ctrl", i), 32'(ctrl_out), 32'(vecs[i].e_ctrl));
         chk($sformatf("t2[%0d]_busy", i), 32'(busy), 32'(vecs[i].e_busy));
         if (vecs[i].chk_ph)
            chk($sformatf("t2[%0d]_phase", i), 32'(phase_idx), 32'(vecs[i].e_ph));
         chk($sformatf("t2[%0d]_pass", i), 32'(pass_cnt), 32'(vecs[i].e_pass));
         chk($sformatf("t2[%0d]_done_n", i), 32'(done_n), 32'(vecs[i].e_done_n));
         chk($sformatf("t2[%0d]_rej", i), 32'(cfg_if.cfg_rej), 32'(vecs[i].e_rej));
         start           = vecs[i].start;
         cfg_if.cfg_wr   = vecs[i].wr;
         cfg_if.cfg_addr = vecs[i].addr;
         cfg_if.cfg_data = vecs[i].data;
         @(negedge clk_sys);
      end
      start         = 1'b0;
      cfg_if.cfg_wr = 1'b0;

      // Out-of-range write, then rerun to confirm the table is intact.
      wr(5'd25, 16'd9, rej);
      chk("t3_oor_rej", 32'(rej), 1);
      pulse_start();
      n = 1;
      while (done_n === 1'b1 && n < 40) begin
         if (n < 4) seen[n] = ctrl_out;
         @(negedge clk_sys);
         n++;
      end
      chk("t3_rerun_len", 32'(n), 17);
      chk("t3_rerun_c1", 32'(seen[1]), 32'h01);
      chk("t3_rerun_c2", 32'(seen[2]), 32'h01);
      chk("t3_rerun_c3", 32'(seen[3]), 32'h02);
      @(negedge clk_sys);

      // Write coinciding with start: phase 0 keeps the old duration.
      wr(5'd0, 16'd4, rej);
      wr(5'd2, 16'h8011, rej);
      wr(5'd24, 16'd1, rej);
      start           = 1'b1;
      cfg_if.cfg_wr   = 1'b1;
      cfg_if.cfg_addr = 5'd0;
      cfg_if.cfg_data = 16'd9;
      @(negedge clk_sys);
      start         = 1'b0;
      cfg_if.cfg_wr = 1'b0;
      chk("t4_same_rej", 32'(cfg_if.cfg_rej), 0);
      n = 0;
      bad = 0;
      while (busy === 1'b1 && n < 50) begin
         if (ctrl_out !== 7'h11) bad++;
         n++;
         @(negedge clk_sys);
      end
      chk("t4_old_len", 32'(n), 4);
      chk("t4_old_pat_bad", 32'(bad), 0);
      @(negedge clk_sys);
      run_measure(7'h11, n, bad);
      chk("t4_new_len", 32'(n), 9);
      chk("t4_new_pat_bad", 32'(bad), 0);
      @(negedge clk_sys);

      // Asynchronous reset mid-phase.
      pulse_start();
      repeat (2) @(negedge clk_sys);
      rst = 1'b1;
      #1;
      chk("t5_async_ctrl", 32'(ctrl_out), 0);
      chk("t5_async_busy", 32'(busy), 0);
      chk("t5_async_done_n", 32'(done_n), 1);
      chk("t5_async_pass", 32'(pass_cnt), 0);
      @(negedge clk_sys);
      chk("t5_hold_done_n", 32'(done_n), 1);
      rst = 1'b0;
      @(negedge clk_sys);
      chk("t5_idle_done_n", 32'(done_n), 1);
      pulse_start();
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("t5_ph%0d_idx", k), 32'(phase_idx), 32'(k));
         chk($sformatf("t5_ph%0d_ctrl", k), 32'(ctrl_out), 0);
         chk($sformatf("t5_ph%0d_busy", k), 32'(busy), 1);
         @(negedge clk_sys);
      end
      chk("t5_end_done_n", 32'(done_n), 0);
      chk("t5_end_pass", 32'(pass_cnt), 1);
      chk("t5_end_busy", 32'(busy), 0);
      @(negedge clk_sys);

`ifdef NOISE_SEQ_ABORT_EN
      wr(5'd0, 16'd2, rej);
      wr(5'd1, 16'd0, rej);
      wr(5'd2, 16'h8005, rej);
      wr(5'd24, 16'd3, rej);
      abort = 1'b1;
      @(negedge clk_sys);
      abort = 1'b0;
      chk("t6_idle_abort_busy", 32'(busy), 0);
      chk("t6_idle_abort_done_n", 32'(done_n), 1);
      pulse_start();
      @(negedge clk_sys);
      @(negedge clk_sys);
      chk("t6_pass2_ctrl", 32'(ctrl_out), 32'h05);
      chk("t6_pass2_cnt", 32'(pass_cnt), 1);
      abort = 1'b1;
      @(negedge clk_sys);
      abort = 1'b0;
      chk("t6_abort_done_n", 32'(done_n), 0);
      chk("t6_abort_ctrl", 32'(ctrl_out), 0);
      chk("t6_abort_busy", 32'(busy), 0);
      chk("t6_abort_pass", 32'(pass_cnt), 1);
      @(negedge clk_sys);
      chk("t6_after_done_n", 32'(done_n), 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
